// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the SPI register bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    // RW bit value that marks a write frame
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits in one frame: RW + address + data
    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // Bit counter must be able to hold FRAME_W itself
    function automatic int cnt_w(input int addr_w, input int data_w);
        return $clog2(frame_w(addr_w, data_w) + 1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall pulses.
// Latency: level after SYNC_STAGES clk, edge pulses in the same cycle as the level change.
// Backpressure: none; input is free-running.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d;

    // Shift the raw input through the synchroniser and remember the previous level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
            level_d <= RESET_LEVEL;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            level_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral with a read/write bank of NUM_REGS registers, oversampled in clk.
// Latency: SYNC_STAGES+1 clk from pin to action; write commits one clk after last sclk rise is seen.
// Backpressure: none; the SPI host paces everything, frames are accepted as they arrive.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       COPI,
    input  logic                       cs,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_q,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       addr_err,
    output logic                       frame_abort
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = cnt_w(ADDR_W, DATA_W);
    localparam int HDR_W   = ADDR_W + 1;
    // Shift register only needs to hold the wider of header and data
    localparam int SH_W    = (HDR_W > DATA_W) ? HDR_W : DATA_W;

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic copi_lvl, unused_copi_rise, unused_copi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(cs),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(COPI),
        .level(copi_lvl), .rise(unused_copi_rise), .fall(unused_copi_fall)
    );

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SH_W-2:0]     shift_q;
    logic [SH_W-1:0]     shift_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic                rw_q;
    logic                addr_ok_q;
    logic [DATA_W-1:0]   shadow;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic                sample, latch_addr, commit, abort, clr_cnt;
    logic [HDR_W-1:0]    hdr;
    logic [ADDR_W-1:0]   hdr_addr;
    logic                hdr_ok;
    logic [DATA_W-1:0]   rd_mux;
    logic                in_data;

    // Incoming bit appended to what has been shifted in so far
    assign shift_nxt = {shift_q, copi_lvl};
    assign hdr       = shift_nxt[HDR_W-1:0];
    assign hdr_addr  = hdr[ADDR_W-1:0];
    assign hdr_ok    = ({1'b0, hdr_addr} < (ADDR_W+1)'(NUM_REGS));
    assign in_data   = (state == ST_DATA) && (state_nxt == ST_DATA);
    assign cipo_oe   = ~cs_lvl;

    // Read mux; an out-of-range address matches nothing and yields zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_mux = regs[i];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and per-cycle control strobes; cs rise beats a coincident last bit
    always_comb begin
        state_nxt  = state;
        sample     = 1'b0;
        latch_addr = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        clr_cnt    = 1'b0;
        if (cs_fall) begin
            state_nxt = ST_ADDR;
            clr_cnt   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_IDLE;
                ST_ADDR: begin
                    if (cs_rise) begin
                        abort     = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (sclk_rise) begin
                        sample = 1'b1;
                        if (bit_cnt == CNT_W'(HDR_W - 1)) begin
                            latch_addr = 1'b1;
                            state_nxt  = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (cs_rise) begin
                        abort     = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (sclk_rise) begin
                        sample = 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                            commit    = 1'b1;
                            state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (cs_rise) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: bit capture, address latch, read shadow, CIPO and atomic write commit
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            addr_ok_q   <= 1'b0;
            shadow      <= '0;
            CIPO        <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= '0;
            addr_err    <= 1'b0;
            frame_abort <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*DATA_W +: DATA_W];
        end else begin
            wr_stb      <= 1'b0;
            addr_err    <= 1'b0;
            frame_abort <= abort;

            if (clr_cnt)     bit_cnt <= '0;
            else if (sample) bit_cnt <= bit_cnt + 1'b1;

            if (sample) shift_q <= shift_nxt[SH_W-2:0];

            if (latch_addr) begin
                addr_q    <= hdr_addr;
                rw_q      <= hdr[ADDR_W];
                addr_ok_q <= hdr_ok;
                addr_err  <= ~hdr_ok;
                shadow    <= (hdr[ADDR_W] == RW_WRITE) ? '0 : rd_mux;
            end

            // CIPO only carries shadow bits while a read frame is in its data phase
            if (!in_data) begin
                CIPO <= 1'b0;
            end else if (sclk_fall && rw_q != RW_WRITE) begin
                CIPO   <= shadow[DATA_W-1];
                shadow <= shadow << 1;
            end

            if (commit && rw_q == RW_WRITE && addr_ok_q) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == ADDR_W'(i)) regs[i] <= shift_nxt[DATA_W-1:0];
                end
                wr_stb  <= 1'b1;
                wr_addr <= addr_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
        assign regs_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: default config plus a 16-bit/3-bit-address config.
// Latency: host-paced, 8 clk per sclk phase.
// Backpressure: none.
module tb_spi_reg_bank;

    localparam logic [127:0] RV2 = 128'h7777_6666_5555_4444_3333_2222_1111_F00D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sclk = 1'b0;
    logic         copi = 1'b0;
    logic         cs = 1'b1;

    logic         cipo1, cipo_oe1, wr_stb1, addr_err1, frame_abort1;
    logic [39:0]  regs_q1;
    logic [6:0]   wr_addr1;

    logic         cipo2, cipo_oe2, wr_stb2, addr_err2, frame_abort2;
    logic [127:0] regs_q2;
    logic [2:0]   wr_addr2;

    int checks   = 0;
    int failures = 0;
    int stb1_cnt = 0, err1_cnt = 0, abort1_cnt = 0, stb2_cnt = 0;

    always #5 clk = ~clk;

    spi_reg_bank u_dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .COPI(copi), .cs(cs),
        .CIPO(cipo1), .cipo_oe(cipo_oe1), .regs_q(regs_q1), .wr_stb(wr_stb1),
        .wr_addr(wr_addr1), .addr_err(addr_err1), .frame_abort(frame_abort1)
    );

    spi_reg_bank #(
        .NUM_REGS(8), .DATA_W(16), .ADDR_W(3), .SYNC_STAGES(2), .RESET_VAL(RV2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .sclk(sclk), .COPI(copi), .cs(cs),
        .CIPO(cipo2), .cipo_oe(cipo_oe2), .regs_q(regs_q2), .wr_stb(wr_stb2),
        .wr_addr(wr_addr2), .addr_err(addr_err2), .frame_abort(frame_abort2)
    );

    // Pulse counters; a held pulse shows up as a count above one
    always @(posedge clk) begin
        if (wr_stb1)      stb1_cnt   <= stb1_cnt + 1;
        if (addr_err1)    err1_cnt   <= err1_cnt + 1;
        if (frame_abort1) abort1_cnt <= abort1_cnt + 1;
        if (wr_stb2)      stb2_cnt   <= stb2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive nbits sclk pulses; bit i is word[width-1-i], extra bits use fill.
    // CIPO of both DUTs is captured just before each sclk rise, MSB first.
    task automatic run_frame(input int nbits, input logic [31:0] word, input int width,
                             input logic fill, input logic close,
                             output logic [31:0] rd1, output logic [31:0] rd2);
        rd1 = '0;
        rd2 = '0;
        cs = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < width) ? word[width-1-i] : fill;
            wait_clk(8);
            rd1 = {rd1[30:0], cipo1};
            rd2 = {rd2[30:0], cipo2};
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        if (close) begin
            wait_clk(8);
            cs = 1'b1;
            wait_clk(12);
        end
    endtask

    logic [31:0] r1, r2;
    int          s0, e0, a0;
    logic [15:0] exp2 [8];

    initial begin
        exp2 = '{16'hF00D, 16'h1111, 16'h2222, 16'h3333,
                 16'h4444, 16'h5555, 16'h6666, 16'h7777};

        wait_clk(4);
        chk("rst_regs1",   regs_q1, 40'h0);
        chk("rst_cipo",    cipo1, 1'b0);
        chk("rst_oe",      cipo_oe1, 1'b0);
        chk("rst_stb",     wr_stb1, 1'b0);
        chk("rst_wr_addr", wr_addr1, 7'h0);
        chk("rst_err",     addr_err1, 1'b0);
        chk("rst_abort",   frame_abort1, 1'b0);
        chk("rst_regs2",   regs_q2, RV2);
        rst = 1'b0;
        wait_clk(4);

        // Write 0xA5 to address 4
        s0 = stb1_cnt;
        run_frame(16, 32'h84A5, 16, 1'b0, 1'b1, r1, r2);
        chk("wr4_regs",    regs_q1, 40'hA5_00_00_00_00);
        chk("wr4_stb",     stb1_cnt - s0, 1);
        chk("wr4_addr",    wr_addr1, 7'h04);

        // Write 0x3C to address 1, then read it back
        run_frame(16, 32'h813C, 16, 1'b0, 1'b1, r1, r2);
        s0 = stb1_cnt;
        run_frame(16, 32'h0100, 16, 1'b0, 1'b1, r1, r2);
        chk("rd1_data",    r1[7:0], 8'h3C);
        chk("rd1_hdr_cipo", r1[15:8], 8'h00);
        chk("rd1_regs",    regs_q1, 40'hA5_00_00_3C_00);
        chk("rd1_no_stb",  stb1_cnt - s0, 0);

        // Out-of-range write and read
        s0 = stb1_cnt;
        e0 = err1_cnt;
        run_frame(16, 32'h90FF, 16, 1'b0, 1'b1, r1, r2);
        chk("oor_wr_err",  err1_cnt - e0, 1);
        chk("oor_wr_stb",  stb1_cnt - s0, 0);
        chk("oor_wr_regs", regs_q1, 40'hA5_00_00_3C_00);
        e0 = err1_cnt;
        run_frame(16, 32'h1000, 16, 1'b0, 1'b1, r1, r2);
        chk("oor_rd_data", r1[7:0], 8'h00);
        chk("oor_rd_err",  err1_cnt - e0, 1);

        // Abort after 10 bits of a write to address 2
        s0 = stb1_cnt;
        a0 = abort1_cnt;
        run_frame(10, 32'h8277, 16, 1'b0, 1'b0, r1, r2);
        chk("oe_in_frame", cipo_oe1, 1'b1);
        wait_clk(8);
        cs = 1'b1;
        wait_clk(12);
        chk("abort_pulse", abort1_cnt - a0, 1);
        chk("abort_nostb", stb1_cnt - s0, 0);
        chk("abort_regs",  regs_q1, 40'hA5_00_00_3C_00);
        chk("oe_idle",     cipo_oe1, 1'b0);
        run_frame(16, 32'h8277, 16, 1'b0, 1'b1, r1, r2);
        chk("post_abort_wr", regs_q1, 40'hA5_00_77_3C_00);

        // 20 sclk pulses in a 16-bit write; trailing ones must be ignored
        s0 = stb1_cnt;
        run_frame(20, 32'h835A, 16, 1'b1, 1'b1, r1, r2);
        chk("long_regs",   regs_q1, 40'hA5_5A_77_3C_00);
        chk("long_stb",    stb1_cnt - s0, 1);
        chk("long_addr",   wr_addr1, 7'h03);

        // Reset in the middle of a frame
        run_frame(6, 32'h84FF, 16, 1'b0, 1'b0, r1, r2);
        rst = 1'b1;
        wait_clk(1);
        chk("mid_rst_regs", regs_q1, 40'h0);
        chk("mid_rst_addr", wr_addr1, 7'h0);
        chk("mid_rst_oe",   cipo_oe1, 1'b0);
        chk("mid_rst_cipo", cipo1, 1'b0);
        chk("mid_rst_regs2", regs_q2, RV2);
        cs = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(8);

        // Wide configuration: read back every reset value, then one write
        for (int i = 0; i < 8; i++) begin
            run_frame(20, 32'(i) << 16, 20, 1'b0, 1'b1, r1, r2);
            chk($sformatf("cfg2_rd%0d", i), r2[15:0], exp2[i]);
        end
        s0 = stb2_cnt;
        run_frame(20, 32'hDBEEF, 20, 1'b0, 1'b1, r1, r2);
        chk("cfg2_wr_reg", regs_q2[95:80], 16'hBEEF);
        chk("cfg2_wr_stb", stb2_cnt - s0, 1);
        chk("cfg2_wr_addr", wr_addr2, 3'd5);
        chk("cfg2_other",  regs_q2[79:64], 16'h4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI mode-0 peripheral exposing a bank of `NUM_REGS` control registers of `DATA_W` bits each, with full write and read-back support over CIPO. It sits between the chip-level SPI pins and the PWM/output-enable logic, and supersedes the fixed five-register write-only peripheral. All SPI inputs are oversampled in the `clk` domain. Writes are committed atomically per frame; aborted frames have no side effects.

## Interface
Parameters:
- `NUM_REGS`, 5: number of registers, valid range 1..2^ADDR_W.
- `DATA_W`, 8: register width, ≥1.
- `ADDR_W`, 7: address field width.
- `SYNC_STAGES`, 2: synchroniser flops per SPI input, ≥2.
- `RESET_VAL`, 0: reset value of every register, NUM_REGS*DATA_W bits.

Ports:
- `clk` input 1: system clock. One clock; all logic is clocked on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sclk` input 1: SPI clock, asynchronous.
- `COPI` input 1: SPI data in, asynchronous.
- `cs` input 1: SPI chip select, active low, asynchronous.
- `CIPO` output 1: SPI data out, MSB-first read data.
- `cipo_oe` output 1: high while `cs` (synchronised) is low.
- `regs_q` output NUM_REGS*DATA_W: register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `wr_stb` output 1: one-cycle pulse when a write commits.
- `wr_addr` output ADDR_W: address of the last committed write.
- `addr_err` output 1: one-cycle pulse when a frame's address is ≥ NUM_REGS.
- `frame_abort` output 1: one-cycle pulse when `cs` rises mid-frame.

## Operation
- Frame format, MSB first, FRAME_W = 1+ADDR_W+DATA_W bits: RW bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- States: IDLE, ADDR (RW and address bits), DATA, DONE.
- IDLE → ADDR on synchronised `cs` falling edge. The bit counter clears.
- COPI is sampled on each synchronised `sclk` rising edge while `cs` is low.
- ADDR → DATA after bit 1+ADDR_W is sampled. On that cycle the address is latched and range-checked:
  - If out of range, `addr_err` pulses.
  - For a read, the shadow register loads `regs_q[addr]`, or 0 if the address is out of range.
- Read data phase: CIPO presents shadow bits MSB first, updated on each synchronised `sclk` falling edge. CIPO is 0 before the data phase, after the data phase, and while `cs` is high.
- DATA → DONE after bit FRAME_W is sampled.
  - A write to an in-range address updates the register, pulses `wr_stb`, and updates `wr_addr`.
  - A write to an out-of-range address is dropped.
- In DONE, extra `sclk` edges are ignored. DONE → IDLE on `cs` rising edge.
- `cs` rising edge in ADDR or DATA: pulse `frame_abort`, return to IDLE, make no register change. A pending read is discarded.
- `cs` falling edge in any state restarts the frame.
- Reset values: `regs_q` = RESET_VAL; `CIPO`, `cipo_oe`, `wr_stb`, `addr_err`, `frame_abort` = 0; `wr_addr` = 0; state IDLE; synchronisers cleared with `cs` synchronised to 1.

## Timing
- Input latency: SYNC_STAGES cycles of synchronisation plus 1 cycle of edge detection.
- Write commit: `regs_q` and `wr_stb` update on the clk edge after the cycle in which the last rising `sclk` edge is detected.
- CIPO update: changes 1 clk after a detected `sclk` falling edge.
- Host requirements:
  - `sclk` high and low phases each ≥ SYNC_STAGES+3 clk cycles.
  - `cs` setup and hold to `sclk` ≥ SYNC_STAGES+2 clk cycles.
- `rst` mid-frame: immediate return to reset values. Any partial frame is lost.
- Simultaneous `cs` rising edge and last-bit `sclk` edge in the same cycle: the frame is treated as aborted.

## Structure
- Shared package `spi_pkg`:
  - Constant for the RW-bit write value.
  - State enum typedef.
  - Function computing FRAME_W.
  - Counter width of $clog2(FRAME_W+1).
- Sub-module `spi_sync_edge`: SYNC_STAGES-deep synchroniser plus rise/fall pulse outputs. Instantiated for `sclk`, `cs` and `COPI` (`COPI` uses the level output only).

## Test plan
- Defaults; write frame 1,0x04,0xA5 → `regs_q[39:32]`=0xA5, `wr_stb` one pulse, `wr_addr`=4, other registers 0.
- Write 0x3C to address 1, then read frame 0,0x01,xx → CIPO bits 0,0,1,1,1,1,0,0 sampled on rising `sclk` edges; registers unchanged.
- Write to address 0x10 (≥ NUM_REGS) → `addr_err` pulses, no `wr_stb`, no register change. Read of 0x10 → CIPO all zeros.
- `cs` raised after 10 bits of a write to address 2 → `frame_abort` pulses, register 2 unchanged. The next full frame writes correctly.
- 20 `sclk` pulses in one write frame → commit occurs after bit 16 only, using the first 16 bits. `rst` asserted mid-frame → all outputs return to reset values.
- Rerun with DATA_W=16, ADDR_W=3, NUM_REGS=8 and nonzero RESET_VAL → frame length 20, and RESET_VAL is read back correctly for every register.
